// File: rtl/instruction_fetch_unit_pkg.sv
// Shared pipeline constants and types for the fetch stage and its pipeline registers.
package instruction_fetch_unit_pkg;

  localparam int unsigned PcWidth     = 32;
  localparam logic [31:0] PcIncrement = 32'd4;
  localparam logic [31:0] ResetVector = 32'h0000_0000;
  // MIPS sll $0,$0,0
  localparam logic [31:0] NopWord     = 32'h0000_0000;

  typedef enum logic {
    StRun,
    StHeld
  } fetch_state_e;

  function automatic logic [PcWidth-1:0] align_word(input logic [PcWidth-1:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/ifid_pipeline_reg.sv
// IF/ID pipeline register: reset > flush (bubble) > load > hold.
module ifid_pipeline_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NopWord
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [31:0] i_instruction,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  logic [31:0] r_instruction;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_instruction <= NOP_WORD;
      r_pc_plus4    <= 32'h0;
      r_valid       <= 1'b0;
    end else if (i_load) begin
      r_instruction <= i_instruction;
      r_pc_plus4    <= i_pc_plus4;
      r_valid       <= 1'b1;
    end
  end

  assign o_instruction = r_instruction;
  assign o_pc_plus4    = r_pc_plus4;
  assign o_valid       = r_valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: owns the PC, drives instruction memory, loads IF/ID and counts fetches.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetVector,
  parameter logic [31:0] NOP_WORD = NopWord
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic [31:0] i_instruction,
  output logic [31:0] o_instr_address,
  output logic [31:0] o_ifid_instruction,
  output logic [31:0] o_ifid_pc_plus4,
  output logic        o_ifid_valid,
  output logic [31:0] o_fetch_count
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_fetch_count;

  logic         w_redirect;
  logic         w_load;
  logic [31:0]  w_target;
  logic [31:0]  w_pc_plus4;

  always_comb begin
    w_redirect = i_jump | i_branch_taken;
    w_load     = ~i_stall & ~w_redirect;
    w_target   = i_jump ? align_word(i_jump_target) : align_word(i_branch_target);
    w_pc_plus4 = r_pc + PcIncrement;
  end

  // Redirect beats stall so a stalled wrong-path word is never replayed.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc          <= RESET_PC;
      r_fetch_count <= 32'h0;
      r_state       <= StRun;
    end else begin
      if (w_redirect) begin
        r_pc <= w_target;
      end else if (!i_stall) begin
        r_pc <= w_pc_plus4;
      end

      if (w_load) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end

      unique case (r_state)
        StRun:   if (i_stall && !w_redirect) r_state <= StHeld;
        StHeld:  if (!i_stall || w_redirect) r_state <= StRun;
        default: r_state <= StRun;
      endcase
    end
  end

  ifid_pipeline_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_ifid (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_load        (w_load),
    .i_flush       (w_redirect),
    .i_instruction (i_instruction),
    .i_pc_plus4    (w_pc_plus4),
    .o_instruction (o_ifid_instruction),
    .o_pc_plus4    (o_ifid_pc_plus4),
    .o_valid       (o_ifid_valid)
  );

  assign o_instr_address = r_pc;
  assign o_fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a scoreboard fed by a reference fetch model.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump;
  logic [31:0] branch_target, jump_target, instruction;
  logic [31:0] instr_address, ifid_instruction, ifid_pc_plus4, fetch_count;
  logic        ifid_valid;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] count;
  } exp_t;

  exp_t q[$];

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_stall            (stall),
    .i_branch_taken     (branch_taken),
    .i_branch_target    (branch_target),
    .i_jump             (jump),
    .i_jump_target      (jump_target),
    .i_instruction      (instruction),
    .o_instr_address    (instr_address),
    .o_ifid_instruction (ifid_instruction),
    .o_ifid_pc_plus4    (ifid_pc_plus4),
    .o_ifid_valid       (ifid_valid),
    .o_fetch_count      (fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] idx;
    idx = {2'b00, addr[31:2]};
    return idx * 32'd3;
  endfunction

  always_comb instruction = mem_word(instr_address);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic stl, input logic br, input logic [31:0] bt,
                      input logic jmp, input logic [31:0] jt);
    exp_t e;
    exp_t got;
    reset = rst; stall = stl; branch_taken = br; branch_target = bt;
    jump = jmp; jump_target = jt;
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;
    end else if (jmp || br) begin
      m_pc    = jmp ? {jt[31:2], 2'b00} : {bt[31:2], 2'b00};
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (!stl) begin
      m_instr = mem_word(m_pc);
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_count = m_count + 32'd1;
      m_pc    = m_pc + 32'd4;
    end
    e = '{addr: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid, count: m_count};
    q.push_back(e);
    @(posedge clk);
    #1;
    got = q.pop_front();
    check("addr",  instr_address,        got.addr);
    check("instr", ifid_instruction,     got.instr);
    check("pc4",   ifid_pc_plus4,        got.pc4);
    check("valid", {31'h0, ifid_valid},  {31'h0, got.valid});
    check("count", fetch_count,          got.count);
  endtask

  task automatic free_step();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0;

    // 1. reset then three free fetches
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("rst_addr",  instr_address, 32'h0);
    check("rst_valid", {31'h0, ifid_valid}, 32'h0);
    check("rst_count", fetch_count, 32'h0);
    repeat (3) free_step();
    check("t1_instr", ifid_instruction, 32'h6);
    check("t1_pc4",   ifid_pc_plus4,    32'hC);
    check("t1_count", fetch_count,      32'd3);

    // 2. stall two cycles at PC=0x10
    free_step();
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t2_state", 32'(dut.r_state), 32'(StHeld));
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t2_addr",  instr_address,    32'h10);
    check("t2_instr", ifid_instruction, 32'h9);
    check("t2_pc4",   ifid_pc_plus4,    32'h10);
    check("t2_count", fetch_count,      32'd4);
    free_step();
    check("t2_rel_instr", ifid_instruction, 32'hC);
    check("t2_rel_pc4",   ifid_pc_plus4,    32'h14);

    // 3. misaligned branch target at PC=0x20
    repeat (3) free_step();
    check("t3_pc", instr_address, 32'h20);
    step(1'b0, 1'b0, 1'b1, 32'h42, 1'b0, 32'h0);
    check("t3_addr",  instr_address,        32'h40);
    check("t3_valid", {31'h0, ifid_valid},  32'h0);
    check("t3_instr", ifid_instruction,     32'h0);
    free_step();
    check("t3_next", ifid_instruction, 32'h30);

    // 4. jump + branch + stall together
    step(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h100);
    check("t4_addr",  instr_address,       32'h100);
    check("t4_valid", {31'h0, ifid_valid}, 32'h0);
    check("t4_state", 32'(dut.r_state),    32'(StRun));
    free_step();
    check("t4_next", ifid_instruction, 32'hC0);

    // 5. reset during stall at PC=0x50
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h50);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t5_addr",  instr_address,       32'h0);
    check("t5_count", fetch_count,         32'h0);
    check("t5_state", 32'(dut.r_state),    32'(StRun));

    // 6. PC wrap
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    free_step();
    check("t6_addr",  instr_address, 32'h0);
    check("t6_pc4",   ifid_pc_plus4, 32'h0);
    check("t6_count", fetch_count,   32'd1);

    if (q.size() != 0) begin
      n_total++;
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage of the 5-stage MIPS pipeline. It is the initiator side of the instruction memory read interface.
- Owns the program counter and drives the byte address to the instruction memory.
- Captures the returned 32-bit instruction into the IF/ID pipeline register.
- Handles stall (hold), branch/jump redirect (flush), and counts issued instructions for debug/perf.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_WORD, 32'h00000000, bubble instruction inserted into IF/ID on flush/reset (MIPS sll $0,$0,0)

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high; overrides all other inputs
Stall  input  1  hazard unit hold request; freezes PC and IF/ID
BranchTaken  input  1  branch resolved taken this cycle
BranchTarget  input  32  branch destination byte address
Jump  input  1  jump (j/jal/jr) redirect this cycle
JumpTarget  input  32  jump destination byte address
Instruction  input  32  word returned by instruction memory for InstrAddress (combinational, same cycle)
InstrAddress  output  32  byte address to instruction memory; equals PC
IFID_Instruction  output  32  registered fetched instruction
IFID_PCPlus4  output  32  registered PC+4 of that instruction
IFID_Valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble
FetchCount  output  32  number of valid instructions latched into IF/ID

Behaviour:
- Memory interface: InstrAddress = PC, purely combinational from the PC register. Memory is word-organised and ignores Address[1:0]; memory returns Instruction in the same cycle. Fetch latency is therefore PC update -> IF/ID capture = 1 clock.
- Reset (Reset=1 at edge), regardless of other inputs, including mid-stall or mid-redirect:
  - PC=RESET_PC
  - IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0
  - FetchCount=0
- Next-PC priority, highest first: Reset > Jump > BranchTaken > Stall > sequential.
  - Jump: PC <= {JumpTarget[31:2],2'b00}.
  - BranchTaken (Jump=0): PC <= {BranchTarget[31:2],2'b00}.
  - Target bits [1:0] are always forced to 0; PC is never misaligned.
  - Stall (no redirect): PC holds.
  - Else: PC <= PC+4, 32-bit modulo; 0xFFFFFFFC wraps to 0x00000000 with no flag.
- IF/ID update, same priority:
  - Redirect (Jump or BranchTaken): flush. IFID_Instruction=NOP_WORD, IFID_PCPlus4 unchanged-don't-care (drive 0), IFID_Valid=0. Wrong-path word is discarded.
  - Redirect concurrent with Stall: the redirect wins for both PC and IF/ID. The flush is required so the stalled wrong-path word is not replayed.
  - Stall only: IF/ID holds all fields, including Valid.
  - Normal: IFID_Instruction=Instruction, IFID_PCPlus4=PC+4, IFID_Valid=1.
- FetchCount increments by 1 on every edge where IF/ID is loaded with Valid=1 (normal case only). It does not increment on stall, flush or reset, and wraps at 2^32.
- Implementation states: the block is a two-state sequencer (RUN, HELD), purely for clarity; outputs depend only on registers.
  - RUN -> HELD when Stall=1 and no redirect.
  - HELD -> RUN when Stall=0 or a redirect occurs.
  - Reset -> RUN.
- No combinational path from Stall/Branch/Jump to InstrAddress; redirect takes effect on the next cycle's address.

Decomposition:
- Shared pipeline package: NOP_WORD constant, PC width (32), PC increment (4), reset vector.
- The IF/ID pipeline register is a natural sub-module, ifid_pipeline_reg. It has inputs load, flush and data, and is reused pattern-wise for ID/EX etc.
- PC and next-PC mux stay in the top.

Test Plan:
Memory is preloaded with memory[i]=i*3.
1. Reset held 2 cycles then released -> InstrAddress=0x0, IFID_Valid=0, FetchCount=0. After 3 free cycles: IFID_Instruction=0x6 (addr 0x8), IFID_PCPlus4=0xC, FetchCount=3.
2. Stall=1 for 2 cycles with PC=0x10 -> InstrAddress stays 0x10, IF/ID holds 0x9/0x10, FetchCount unchanged. On release the next capture is 0xC, with PCPlus4=0x14.
3. BranchTaken=1, BranchTarget=0x42 at PC=0x20 -> next InstrAddress=0x40, IFID_Valid=0, IFID_Instruction=0. The following cycle captures 0x30 (48), Valid=1.
4. Jump=1 (JumpTarget=0x100) and BranchTaken=1 (BranchTarget=0x80) with Stall=1 together -> PC=0x100 (jump wins over stall), IF/ID flushed. Next capture is 0xC0 (192).
5. Reset asserted during Stall with PC=0x50 -> next edge PC=0x0, IFID_Valid=0, FetchCount=0, FSM in RUN.
6. PC forced near wrap via Jump to 0xFFFFFFFC, then one free cycle -> InstrAddress=0x00000000, IFID_PCPlus4=0x00000000, FetchCount+1.
